load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage between the multi-cycle RV32I processor FSM and a word-wide synchronous data RAM. It accepts one load or store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW), performs little-endian byte-lane alignment and sign/zero extension, and returns a single-cycle response pulse. The RAM has no byte enables, so sub-word stores run as an internal read-modify-write sequence. Alignment, range and encoding faults are reported without touching the RAM.

Parameters:
ADDR_WIDTH, 10, word-address bits of the data RAM; the valid byte range is 0 .. 2^(ADDR_WIDTH+2)-1.
RESET_RDATA, 32'h0000_0000, reset and store-response value of resp_rdata.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; a request is accepted on any cycle where req_valid && req_ready
req_op  in  4  bit3 = 1 store / 0 load; bits[2:0] = RV32I funct3
req_addr  in  32  byte address
req_wdata  in  32  store data; low bits are used for SB/SH
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data, held until the next response
resp_err  out  1  fault flag, valid while resp_valid is high
ram_addr  out  ADDR_WIDTH  word address, equal to req_addr[ADDR_WIDTH+1:2]
ram_we  out  1  RAM write strobe
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid one cycle after the address is presented with ram_we=0

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=RESET_RDATA, ram_we=0, ram_addr=0, ram_wdata=0. All registers are asynchronously cleared.
- Reset mid-operation aborts the access. ram_we drops immediately. A pending RMW write is never issued.
- States: IDLE, READ, WAIT, WRITE, RESP.
- On accept, the unit latches op, addr and wdata, and evaluates faults in this priority order:
  - illegal encoding: load funct3 ∈ {3,6,7}, or store funct3 ≥ 3;
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0;
  - out of range: addr[31:ADDR_WIDTH+2]≠0.
- State sequence after accept:
  - fault: RESP with resp_err=1; RAM untouched; resp_rdata unchanged.
  - load: READ → WAIT → RESP.
  - SW: WRITE → RESP.
  - SB/SH: READ → WAIT → WRITE → RESP.
- READ drives ram_addr with ram_we=0. WAIT captures ram_rdata: it is extracted for loads and merged with the new lane data for RMW stores.
- WRITE asserts ram_we for exactly one cycle.
- Latency, from the accept edge to the cycle in which resp_valid is high:
  - fault: 1 cycle
  - SW: 2 cycles
  - load: 3 cycles
  - SB/SH: 4 cycles
- RESP asserts resp_valid for one cycle, then the FSM returns to IDLE. req_ready goes high again in the next cycle; there is no back-to-back accept from RESP.
- Lane select is addr[1:0]. LB/LBU use byte lane addr[1:0]. LH/LHU use bits [16*addr[1]+15 : 16*addr[1]]. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores set resp_rdata=RESET_RDATA on a successful response.
- There is no response backpressure. req_valid is ignored outside IDLE.

Optional Feature:
LSU_MISALIGN_TRAP_EN:
- Defined: misaligned accesses fault as described above.
- Undefined: misalignment is not a fault. The low address bits are forced to the natural alignment (halfword: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally. Encoding and range faults are unchanged.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - the state enum;
  - the req_op bit-field positions.
- One sub-module, lsu_lane_align, is purely combinational with two functions:
  - extract: word, addr[1:0], funct3 → extended data;
  - merge: old word, new data, addr[1:0], funct3 → merged word.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Reset, then preload RAM word 3 = 32'h8899_AABB. LB @0x0C → resp_rdata=32'hFFFF_FFBB, err=0, resp 3 cycles after accept. LBU @0x0E → 32'h0000_0099. LH @0x0E → 32'hFFFF_8899.
- SW 32'h1234_5678 @0x10 → ram_we high for 1 cycle with ram_addr=4 and ram_wdata=32'h1234_5678; resp after 2 cycles; LW @0x10 then returns 32'h1234_5678.
- Word 4 = 32'h1234_5678. SB 32'h0000_00AB @0x11 → RMW writes 32'h1234_AB78. SH 32'h0000_CDEF @0x12 → writes 32'hCDEF_AB78; resp after 4 cycles.
- LW @0x06 with LSU_MISALIGN_TRAP_EN → resp_err=1 after 1 cycle, ram_we never asserted, resp_rdata unchanged. Without the macro → reads word 1.
- Faults with ADDR_WIDTH=10: req_op=4'b0011 (load funct3=3) → err=1. LW @0x0000_1000 → err=1 (out of range). Store funct3=4 → err=1, no RAM write.
- Assert rst during WAIT of an SB → ram_we stays 0, RAM word unchanged, req_ready=1 and resp_valid=0 immediately; a fresh LW after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 encodings for the load/store widths
//   - FSM state encoding
//   - bit-field positions inside req_op
// Optional build macro used by the design: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // req_op layout: bit 3 selects store, bits 2:0 carry funct3
  localparam int OP_STORE_BIT = 3;
  localparam int OP_F3_MSB    = 2;
  localparam int OP_F3_LSB    = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational little-endian byte-lane alignment.
//   word      : RAM word to extract load data from
//   old_word  : RAM word to merge sub-word store data into
//   new_data  : store data (low byte/halfword used for SB/SH)
//   addr_lo   : byte offset within the word
//   funct3    : access width / signedness
//   extracted : sign/zero extended load result
//   merged    : old_word with the addressed lane(s) replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  lo,
                                          input logic [2:0]  f3);
    logic [31:0] shb;
    logic [31:0] shh;
    logic [31:0] res;
    // Byte lanes shift by 8*lo; halfwords only by 16*lo[1]
    shb = w >> {lo, 3'b000};
    shh = w >> {lo[1], 4'b0000};
    case (f3)
      F3_B:    res = {{24{shb[7]}}, shb[7:0]};
      F3_BU:   res = {24'h0, shb[7:0]};
      F3_H:    res = {{16{shh[15]}}, shh[15:0]};
      F3_HU:   res = {16'h0, shh[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] nd,
                                        input logic [1:0]  lo,
                                        input logic [2:0]  f3);
    logic [31:0] mask;
    logic [31:0] lane;
    logic [4:0]  sh;
    logic [31:0] res;
    if (f3 == F3_B) begin
      sh   = {lo, 3'b000};
      mask = 32'h0000_00FF << sh;
      lane = {24'h0, nd[7:0]} << sh;
      res  = (old_w & ~mask) | lane;
    end else if (f3 == F3_H) begin
      sh   = {lo[1], 4'b0000};
      mask = 32'h0000_FFFF << sh;
      lane = {16'h0, nd[15:0]} << sh;
      res  = (old_w & ~mask) | lane;
    end else begin
      res = nd;
    end
    return res;
  endfunction

  assign extracted = extract(word, addr_lo, funct3);
  assign merged    = merge(old_word, new_data, addr_lo, funct3);

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage between the RV32I core FSM and a word-wide
// synchronous data RAM without byte enables. Sub-word stores run as a
// read-modify-write sequence; faulting requests never touch the RAM.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_op/req_addr/req_wdata : request handshake
//   resp_valid/resp_rdata/resp_err                : one-cycle response
//   ram_addr/ram_we/ram_wdata/ram_rdata           : RAM interface
// Build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword and
// word accesses fault; otherwise the low address bits are forced to the
// natural alignment and the access proceeds.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  lsu_state_t state_reg, state_next;

  logic [3:0]            op_reg;
  logic [ADDR_WIDTH+1:0] addr_reg;
  logic [31:0]           word_reg;   // store data, later the merged RMW word
  logic [31:0]           rdata_reg;
  logic                  err_reg;

  // Request decode
  logic [2:0]            req_f3;
  logic                  req_store;
  logic                  illegal;
  logic                  out_of_range;
  logic                  fault;
  logic [ADDR_WIDTH+1:0] addr_aligned;

  assign req_f3    = req_op[OP_F3_MSB:OP_F3_LSB];
  assign req_store = req_op[OP_STORE_BIT];

  always_comb begin
    illegal      = 1'b0;
    out_of_range = |req_addr[31:ADDR_WIDTH+2];
    addr_aligned = req_addr[ADDR_WIDTH+1:0];
    fault        = 1'b0;
    if (req_store)
      illegal = (req_f3 > F3_W);
    else
      illegal = (req_f3 == 3'd3) || (req_f3 == 3'd6) || (req_f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
    fault = illegal
         || ((req_f3[1:0] == 2'd1) && req_addr[0])
         || ((req_f3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00))
         || out_of_range;
`else
    // funct3[1:0] gives the width for every legal encoding
    if (req_f3[1:0] == 2'd1)
      addr_aligned[0] = 1'b0;
    else if (req_f3[1:0] == 2'd2)
      addr_aligned[1:0] = 2'b00;
    fault = illegal || out_of_range;
`endif
  end

  // Lane alignment
  logic [31:0] extracted;
  logic [31:0] merged;

  lsu_lane_align u_align (
    .word      (ram_rdata),
    .old_word  (ram_rdata),
    .new_data  (word_reg),
    .addr_lo   (addr_reg[1:0]),
    .funct3    (op_reg[OP_F3_MSB:OP_F3_LSB]),
    .extracted (extracted),
    .merged    (merged)
  );

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (fault)
            state_next = RESP;
          else if (req_store && (req_f3 == F3_W))
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ:    state_next = WAIT;
      WAIT:    state_next = op_reg[OP_STORE_BIT] ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      addr_reg  <= '0;
      word_reg  <= '0;
      rdata_reg <= RESET_RDATA;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        op_reg   <= req_op;
        addr_reg <= addr_aligned;
        word_reg <= req_wdata;
        err_reg  <= fault;
      end
      // RAM data is valid in WAIT: extract for loads, merge for RMW stores
      if (state_reg == WAIT) begin
        if (op_reg[OP_STORE_BIT])
          word_reg <= merged;
        else
          rdata_reg <= extracted;
      end
      if (state_reg == WRITE)
        rdata_reg <= RESET_RDATA;
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_err   = err_reg && (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign ram_addr   = addr_reg[ADDR_WIDTH+1:2];
  assign ram_we     = (state_reg == WRITE);
  assign ram_wdata  = word_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// synchronous RAM (registered read, one write port plus a preload port).
module tb_load_store_unit;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [31:0]   pre_data;

  logic [31:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_data;
    else if (ram_we)
      mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  load_store_unit #(.ADDR_WIDTH(AW), .RESET_RDATA(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request and watch the bus until the response pulse.
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic err,
                        output int we_cnt, output logic [31:0] we_data,
                        output logic [AW-1:0] we_addr);
    lat = 0; rdata = '0; err = 1'b0; we_cnt = 0; we_data = '0; we_addr = '0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ram_we) begin
        we_cnt++; we_data = ram_wdata; we_addr = ram_addr;
      end
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      $display("FAIL timeout op=%h addr=%h: no resp_valid within 10 cycles", op, addr);
      errors++;
    end
    $display("txn op=%h addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d writes=%0d wdata=%h waddr=%0d",
             op, addr, wdata, rdata, err, lat, we_cnt, we_data, we_addr);
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 1'b1) begin $display("FAIL reset_ready got %b want 1", req_ready); errors++; end
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      $display("FAIL reset_resp got valid=%b err=%b want 0 0", resp_valid, resp_err); errors++;
    end
    checks++;
    if (resp_rdata !== 32'h0) begin $display("FAIL reset_rdata got %h want 00000000", resp_rdata); errors++; end
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== 32'h0) begin
      $display("FAIL reset_ram got we=%b addr=%h wdata=%h want 0 0 0", ram_we, ram_addr, ram_wdata); errors++;
    end
  endtask

  task automatic test_loads;
    int lat; logic [31:0] rd; logic er; int wc; logic [31:0] wd; logic [AW-1:0] wa;
    logic [3:0]  ops [6]  = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0000};
    logic [31:0] adr [6]  = '{32'h0C, 32'h0E, 32'h0E, 32'h0C, 32'h0C, 32'h0F};
    logic [31:0] exp [6]  = '{32'hFFFF_FFBB, 32'h0000_0099, 32'hFFFF_8899,
                              32'h0000_AABB, 32'h8899_AABB, 32'hFFFF_FF88};
    preload(10'd3, 32'h8899_AABB);
    for (int i = 0; i < 6; i++) begin
      do_req(ops[i], adr[i], 32'h0, lat, rd, er, wc, wd, wa);
      checks++;
      if (rd !== exp[i] || er !== 1'b0) begin
        $display("FAIL load_%0d got rdata=%h err=%b want %h 0", i, rd, er, exp[i]); errors++;
      end
      checks++;
      if (lat != 3 || wc != 0) begin
        $display("FAIL load_lat_%0d got lat=%0d writes=%0d want 3 0", i, lat, wc); errors++;
      end
    end
  endtask

  task automatic test_store_word;
    int lat; logic [31:0] rd; logic er; int wc; logic [31:0] wd; logic [AW-1:0] wa;
    do_req(4'b1010, 32'h10, 32'h1234_5678, lat, rd, er, wc, wd, wa);
    checks++;
    if (wc != 1 || wa !== 10'd4 || wd !== 32'h1234_5678) begin
      $display("FAIL sw_write got writes=%0d addr=%0d data=%h want 1 4 12345678", wc, wa, wd); errors++;
    end
    checks++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin
      $display("FAIL sw_resp got lat=%0d err=%b rdata=%h want 2 0 00000000", lat, er, rd); errors++;
    end
    do_req(4'b0010, 32'h10, 32'h0, lat, rd, er, wc, wd, wa);
    checks++;
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      $display("FAIL sw_readback got %h err=%b want 12345678 0", rd, er); errors++;
    end
  endtask

  task automatic test_rmw;
    int lat; logic [31:0] rd; logic er; int wc; logic [31:0] wd; logic [AW-1:0] wa;
    do_req(4'b1000, 32'h11, 32'h0000_00AB, lat, rd, er, wc, wd, wa);
    checks++;
    if (wc != 1 || wa !== 10'd4 || wd !== 32'h1234_AB78 || lat != 4 || er !== 1'b0) begin
      $display("FAIL sb_rmw got writes=%0d addr=%0d data=%h lat=%0d err=%b want 1 4 1234ab78 4 0",
               wc, wa, wd, lat, er); errors++;
    end
    do_req(4'b1001, 32'h12, 32'h0000_CDEF, lat, rd, er, wc, wd, wa);
    checks++;
    if (wc != 1 || wd !== 32'hCDEF_AB78 || lat != 4 || er !== 1'b0) begin
      $display("FAIL sh_rmw got writes=%0d data=%h lat=%0d err=%b want 1 cdefab78 4 0", wc, wd, lat, er);
      errors++;
    end
    checks++;
    if (mem[4] !== 32'hCDEF_AB78) begin $display("FAIL rmw_mem got %h want cdefab78", mem[4]); errors++; end
  endtask

  task automatic test_faults;
    int lat; logic [31:0] rd; logic er; int wc; logic [31:0] wd; logic [AW-1:0] wa;
    logic [3:0]  ops [3] = '{4'b0011, 4'b0010, 4'b1100};
    logic [31:0] adr [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0010};
    do_req(4'b0010, 32'h0C, 32'h0, lat, rd, er, wc, wd, wa);   // known resp_rdata
    for (int i = 0; i < 3; i++) begin
      do_req(ops[i], adr[i], 32'hFFFF_FFFF, lat, rd, er, wc, wd, wa);
      checks++;
      if (er !== 1'b1 || lat != 1 || wc != 0) begin
        $display("FAIL fault_%0d got err=%b lat=%0d writes=%0d want 1 1 0", i, er, lat, wc); errors++;
      end
      checks++;
      if (rd !== 32'h8899_AABB) begin
        $display("FAIL fault_rdata_%0d got %h want 8899aabb", i, rd); errors++;
      end
    end
    checks++;
    if (mem[4] !== 32'hCDEF_AB78) begin $display("FAIL fault_mem got %h want cdefab78", mem[4]); errors++; end
  endtask

  task automatic test_misalign;
    int lat; logic [31:0] rd; logic er; int wc; logic [31:0] wd; logic [AW-1:0] wa;
    preload(10'd1, 32'hDEAD_BEEF);
    do_req(4'b0010, 32'h06, 32'h0, lat, rd, er, wc, wd, wa);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (er !== 1'b1 || lat != 1 || wc != 0 || rd !== 32'h8899_AABB) begin
      $display("FAIL misalign_trap got err=%b lat=%0d writes=%0d rdata=%h want 1 1 0 8899aabb",
               er, lat, wc, rd); errors++;
    end
`else
    checks++;
    if (er !== 1'b0 || lat != 3 || rd !== 32'hDEAD_BEEF) begin
      $display("FAIL misalign_fix got err=%b lat=%0d rdata=%h want 0 3 deadbeef", er, lat, rd); errors++;
    end
`endif
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er; int wc; logic [31:0] wd; logic [AW-1:0] wa;
    logic we_seen;
    preload(10'd5, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1000; req_addr = 32'h14; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin $display("FAIL busy_ready got %b want 0", req_ready); errors++; end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      $display("FAIL mid_reset got we=%b ready=%b valid=%b want 0 1 0", ram_we, req_ready, resp_valid);
      errors++;
    end
    we_seen = 1'b0;
    repeat (3) begin @(negedge clk); we_seen |= ram_we; end
    rst = 1'b1;
    repeat (4) begin @(negedge clk); we_seen |= ram_we; end
    checks++;
    if (we_seen !== 1'b0 || mem[5] !== 32'h1122_3344) begin
      $display("FAIL mid_reset_ram got we_seen=%b mem=%h want 0 11223344", we_seen, mem[5]); errors++;
    end
    do_req(4'b0010, 32'h14, 32'h0, lat, rd, er, wc, wd, wa);
    checks++;
    if (rd !== 32'h1122_3344 || er !== 1'b0 || lat != 3) begin
      $display("FAIL post_reset_lw got rdata=%h err=%b lat=%0d want 11223344 0 3", rd, er, lat); errors++;
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    test_loads;
    test_store_word;
    test_rmw;
    test_faults;
    test_misalign;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
